operand_seq_gen: RTL and testbench

//  Stimulus-side counterpart of the registered modulo-2^WIDTH adder checker.

---
 rtl/operand_seq_pkg.sv | 33 +++
 rtl/galois_lfsr.sv | 46 ++++
 rtl/operand_seq_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_operand_seq_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_seq_pkg.sv
// Shared types and helpers for the operand sequence generator.
//
// Contents:
//   state_e     - sequencer states: IDLE, CORNER, RANDOM, DONE
//   mode_e      - latched sequence mode: M_CORNER, M_RANDOM, M_BOTH
//   NUM_CORNER  - number of vectors in the fixed corner-case walk
//   corner_vec  - returns {a, b} for corner index idx, each zero-extended to 64 bits
package operand_seq_pkg;

  typedef enum logic [1:0] {IDLE, CORNER, RANDOM, DONE} state_e;

  typedef enum logic [1:0] {M_CORNER = 2'd0, M_RANDOM = 2'd1, M_BOTH = 2'd2} mode_e;

  localparam int NUM_CORNER = 4;

  // The corner walk is 0/0, max/1, max/max, msb/msb.
  // a occupies bits [127:64] and b occupies bits [63:0].
  // The caller truncates each half to its operand width.
  // This helper supports widths from 1 to 64.
  function automatic logic [127:0] corner_vec(input logic [1:0] idx, input int unsigned width);
    logic [63:0] max_v;
    logic [63:0] msb_v;
    max_v = {64{1'b1}} >> (64 - width);
    msb_v = 64'd1 << (width - 1);
    case (idx)
      2'd0:    corner_vec = {64'd0, 64'd0};
      2'd1:    corner_vec = {max_v, 64'd1};
      2'd2:    corner_vec = {max_v, max_v};
      default: corner_vec = {msb_v, msb_v};
    endcase
  endfunction

endpackage

// File: rtl/galois_lfsr.sv
// Galois LFSR shifting right, with feedback mask TAPS applied when the bit shifted out is 1.
//
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset (reset value is SEED)
//   load        - reload SEED; takes priority over step
//   step        - advance one position
//   state       - current register contents
//   next_state  - value the register takes after one step
//                 (this lets the consumer register the upcoming vector in the same cycle)
module galois_lfsr #(
  parameter int           N    = 16,
  parameter logic [N-1:0] SEED = 16'hACE1,
  parameter logic [N-1:0] TAPS = 16'hB400
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  output logic [N-1:0] state,
  output logic [N-1:0] next_state
);

  logic [N-1:0] state_q;
  logic [N-1:0] state_d;

  always_comb begin
    next_state = {1'b0, state_q[N-1:1]} ^ (state_q[0] ? TAPS : '0);
    state_d    = state_q;
    if (load) begin
      state_d = SEED;
    end else if (step) begin
      state_d = next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/operand_seq_gen.sv
// Operand sequence generator.
// It emits (a, b, exp_y = a+b mod 2^WIDTH) over a valid/ready stream.
// The sequence is a fixed corner walk, LFSR pseudo-random vectors, or corners followed by random vectors.
//
// Ports:
//   clk, rst_n        - clock and asynchronous active-low reset
//   start             - begin a sequence; honoured only in IDLE
//   mode              - 0 corner, 1 random, 2 corner then random, 3 same as 0
//   count             - number of random vectors; latched when start is accepted
//   o_valid / o_ready - output handshake
//   a, b, exp_y       - operands and expected truncated sum, registered together
//   exp_c             - carry out of a+b; present only when SEQ_CARRY_EN is defined
//   busy              - high from accepted start until DONE is left
//   done              - one-cycle completion pulse
//   issued            - accepted transfers since the last start; saturates
//
// Build option: define SEQ_CARRY_EN to add the exp_c output.
module operand_seq_gen
  import operand_seq_pkg::*;
#(
  parameter int                   WIDTH = 8,
  parameter int                   CNT_W = 16,
  parameter logic [2*WIDTH-1:0]   SEED  = 16'hACE1,
  parameter logic [2*WIDTH-1:0]   TAPS  = 16'hB400
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] count,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] exp_y,
`ifdef SEQ_CARRY_EN
  output logic             exp_c,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] issued
);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [1:0]         idx_q, idx_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
`ifdef SEQ_CARRY_EN
  logic               c_q, c_d;
`endif

  logic               lfsr_load;
  logic               lfsr_step;
  logic [2*WIDTH-1:0] lfsr_state;
  logic [2*WIDTH-1:0] lfsr_next;
  logic               accept;

  galois_lfsr #(
    .N    (2 * WIDTH),
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (lfsr_load),
    .step       (lfsr_step),
    .state      (lfsr_state),
    .next_state (lfsr_next)
  );

  assign accept = valid_q & o_ready;

  // The LFSR always holds the vector on display during RANDOM.
  // On an accept, the output registers take next_state while the LFSR steps, so vectors follow with no bubble.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    a_d       = a_q;
    b_d       = b_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    issued_d  = issued_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    if (accept && (issued_q != '1)) begin
      issued_d = issued_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d     = count;
          issued_d  = '0;
          lfsr_load = 1'b1;
          busy_d    = 1'b1;
          case (mode)
            2'd1:    mode_d = M_RANDOM;
            2'd2:    mode_d = M_BOTH;
            default: mode_d = M_CORNER;
          endcase
          if (mode == 2'd1) begin
            state_d = RANDOM;
            valid_d = (count != '0);
            a_d     = SEED[2*WIDTH-1:WIDTH];
            b_d     = SEED[WIDTH-1:0];
          end else begin
            state_d = CORNER;
            idx_d   = 2'd0;
            valid_d = 1'b1;
            a_d     = WIDTH'(corner_vec(2'd0, WIDTH) >> 64);
            b_d     = WIDTH'(corner_vec(2'd0, WIDTH));
          end
        end
      end

      CORNER: begin
        if (accept) begin
          if (idx_q == 2'(NUM_CORNER - 1)) begin
            if (mode_q == M_BOTH) begin
              state_d = RANDOM;
              valid_d = (rem_q != '0);
              a_d     = lfsr_state[2*WIDTH-1:WIDTH];
              b_d     = lfsr_state[WIDTH-1:0];
            end else begin
              state_d = DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + 2'd1;
            a_d   = WIDTH'(corner_vec(idx_q + 2'd1, WIDTH) >> 64);
            b_d   = WIDTH'(corner_vec(idx_q + 2'd1, WIDTH));
          end
        end
      end

      RANDOM: begin
        // If valid is low here, count was zero, so there is nothing to issue.
        if (!valid_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (accept) begin
          rem_d     = rem_q - 1'b1;
          lfsr_step = 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            a_d = lfsr_next[2*WIDTH-1:WIDTH];
            b_d = lfsr_next[WIDTH-1:0];
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

`ifdef SEQ_CARRY_EN
    {c_d, y_d} = {1'b0, a_d} + {1'b0, b_d};
`else
    y_d = a_d + b_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= M_CORNER;
      rem_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      issued_q <= '0;
`ifdef SEQ_CARRY_EN
      c_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      a_q      <= a_d;
      b_q      <= b_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      issued_q <= issued_d;
`ifdef SEQ_CARRY_EN
      c_q      <= c_d;
`endif
    end
  end

  assign o_valid = valid_q;
  assign a       = a_q;
  assign b       = b_q;
  assign exp_y   = y_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign issued  = issued_q;
`ifdef SEQ_CARRY_EN
  assign exp_c   = c_q;
`endif

endmodule

// File: tb/tb_operand_seq_gen.sv
// Scoreboard bench for operand_seq_gen.
// Expected vectors come from a reference model of the sequence rules and are pushed into a queue.
// A negedge monitor pops and compares the queue on every accepted transfer.
// The same monitor checks that output data stays stable during stalls.
module tb_operand_seq_gen;

  localparam int          W    = 8;
  localparam int          CW   = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [CW-1:0] count = '0;
  logic          o_ready = 1'b0;
  logic          o_valid;
  logic [W-1:0]  a, b, exp_y;
  logic          busy, done;
  logic [CW-1:0] issued;
`ifdef SEQ_CARRY_EN
  logic          exp_c;
`endif

  operand_seq_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .count   (count),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .a       (a),
    .b       (b),
    .exp_y   (exp_y),
`ifdef SEQ_CARRY_EN
    .exp_c   (exp_c),
`endif
    .busy    (busy),
    .done    (done),
    .issued  (issued)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
  } vec_t;

  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic held = 1'b0;
  vec_t held_v;
  vec_t mon_v;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk_vec(input int va, input int vb);
    vec_t v;
    v.a = W'(va);
    v.b = W'(vb);
    v.y = W'((va + vb) % (1 << W));
    return v;
  endfunction

  // Reference model: the corner walk comes from arithmetic.
  // Random vectors come from a Galois shift of the 2W-bit seed.
  function automatic void push_seq(input int m, input int cnt);
    int maxv, msbv, x;
    maxv = (1 << W) - 1;
    msbv = 1 << (W - 1);
    if (m != 1) begin
      exp_q.push_back(mk_vec(0, 0));
      exp_q.push_back(mk_vec(maxv, 1));
      exp_q.push_back(mk_vec(maxv, maxv));
      exp_q.push_back(mk_vec(msbv, msbv));
    end
    if (m == 1 || m == 2) begin
      x = int'(SEED);
      for (int i = 0; i < cnt; i++) begin
        exp_q.push_back(mk_vec(x / 256, x % 256));
        x = (x / 2) ^ (((x % 2) == 1) ? int'(TAPS) : 0);
      end
    end
  endfunction

  function automatic logic ready_for(input int pm, input int cyc);
    if (pm == 0) return 1'b1;
    if (pm == 1) return ((cyc - 1) % 3) == 0;
    return $urandom_range(0, 2) != 0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check_output("stall_valid", 32'(o_valid), 32'd1);
        check_output("stall_data", 32'({a, b, exp_y}), 32'({held_v.a, held_v.b, held_v.y}));
      end
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL unexpected_vec: got a=%0h b=%0h, required none", a, b);
        end else begin
          mon_v = exp_q.pop_front();
          check_output("vec_a", 32'(a), 32'(mon_v.a));
          check_output("vec_b", 32'(b), 32'(mon_v.b));
          check_output("vec_y", 32'(exp_y), 32'(mon_v.y));
        end
        held = 1'b0;
      end else if (o_valid) begin
        held     = 1'b1;
        held_v.a = a;
        held_v.b = b;
        held_v.y = exp_y;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic apply_stimulus(input int m, input int cnt, input int pm, input bit pulse_busy);
    int n, cyc, exp_done;
    bit seen;
    n        = ((m != 1) ? 4 : 0) + ((m == 1 || m == 2) ? cnt : 0);
    exp_done = (cnt == 0 && (m == 1 || m == 2)) ? n + 2 : n + 1;
    push_seq(m, cnt);
    @(posedge clk);
    #1;
    start   = 1'b1;
    mode    = m[1:0];
    count   = CW'(cnt);
    o_ready = 1'b0;
    cyc     = 0;
    seen    = 1'b0;
    while (cyc < n * 6 + 20 && !seen) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      count = CW'($urandom);
      mode  = 2'($urandom);
      if (cyc == 1) begin
        check_output("busy_after_start", 32'(busy), 32'd1);
        check_output("first_valid", 32'(o_valid), 32'(n > 0));
        if (m == 1 && cnt > 0) check_output("first_rand_a", 32'(a), 32'(SEED[15:8]));
        if (pulse_busy) begin
          start = 1'b1;
          mode  = 2'd0;
        end
      end
      if (done) seen = 1'b1;
      else o_ready = ready_for(pm, cyc);
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL done_timeout: got no done in %0d cycles, required done", cyc);
    end else begin
      if (pm == 0) check_output("done_cycle", 32'(cyc), 32'(exp_done));
      check_output("issued", 32'(issued), 32'(n));
      check_output("valid_at_done", 32'(o_valid), 32'd0);
      check_output("busy_at_done", 32'(busy), 32'd1);
      check_output("queue_drained", 32'(exp_q.size()), 32'd0);
      start = 1'b1;
      mode  = 2'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_output("done_pulse_len", 32'(done), 32'd0);
      check_output("busy_after_done", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check_output("start_at_done_ignored", 32'({o_valid, busy}), 32'd0);
    end
    exp_q.delete();
  endtask

  initial begin
    // While reset is held, toggling start must have no effect.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      start = ~start;
    end
    start = 1'b0;
    check_output("rst_outputs", 32'({o_valid, busy, done, a, b, exp_y}), 32'd0);
    check_output("rst_issued", 32'(issued), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("idle_after_rst", 32'({o_valid, busy, done}), 32'd0);

    apply_stimulus(0, 0, 0, 1'b0);
    apply_stimulus(1, 5, 0, 1'b0);
    apply_stimulus(2, 3, 1, 1'b0);
    apply_stimulus(1, 0, 0, 1'b1);
    apply_stimulus(3, 5, 0, 1'b0);

    // Reset asserted mid-sequence must abort at once, with no done pulse.
    push_seq(0, 0);
    @(posedge clk);
    #1;
    start   = 1'b1;
    mode    = 2'd0;
    o_ready = 1'b0;
    @(posedge clk);
    #1;
    start   = 1'b0;
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("second_corner_a", 32'(a), 32'hFF);
    rst_n = 1'b0;
    #1;
    check_output("abort_outputs", 32'({o_valid, busy, done, a, b, exp_y}), 32'd0);
    check_output("abort_issued", 32'(issued), 32'd0);
    exp_q.delete();
    o_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("abort_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    apply_stimulus(0, 0, 0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), 2, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
